// File: rtl/ins_encoder_if.sv
// ins_encoder_if -- field-set handshake between an instruction source and
// the encoder.
//   in_valid : source presents a field set
//   in_ready : encoder accepts the field set this cycle
//   opcode   : [2:0] opcode field
//   rt_rd    : rt/rd register select
//   rs       : rs register select
//   signIn   : [2:0] immediate field
//   last     : final instruction of the program
// The master modport is the source side; the slave modport is the encoder side.
interface ins_encoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] opcode;
   logic       rt_rd;
   logic       rs;
   logic [2:0] signIn;
   logic       last;

   modport master (
      output in_valid, opcode, rt_rd, rs, signIn, last,
      input  in_ready
   );

   modport slave (
      input  in_valid, opcode, rt_rd, rs, signIn, last,
      output in_ready
   );
endinterface

// File: rtl/ins_encoder.sv
// ins_encoder -- packs instruction fields into 8-bit words and writes them
// to program memory at consecutive addresses.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse that begins or restarts a load
//   bus       : field-set handshake (slave side)
//   mem_we    : program memory write strobe, one cycle per accepted word
//   mem_addr  : write address, held between writes
//   mem_wdata : packed word {opcode, rt_rd, rs, signIn}, held between writes
//   count     : words accepted since the last start (saturates at DEPTH)
//   full      : count == DEPTH
//   done      : the final word of the program has been accepted
//   err       : sticky; a field set was offered while full without last
module ins_encoder #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   ins_encoder_if.slave  bus,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    wdata_q;
   logic          full_w;
   logic          accept;

   assign full_w       = (count_q == (AW+1)'(DEPTH));
   // start blocks the handshake so a restart never coincides with an accept.
   assign bus.in_ready = (state_q == LOAD) && !full_w && !start;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      if (start) begin
         state_d = LOAD;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (accept) begin
            // accept already implies !full, so count cannot pass DEPTH
            count_d = count_q + 1'b1;
            if (bus.last) state_d = DONE;
         end
         // full in LOAD only happens without last; further offers are overflow
         if (state_q == LOAD && full_w && bus.in_valid) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
         we_q    <= accept;
         if (accept) begin
            addr_q  <= count_q[AW-1:0];
            wdata_q <= {bus.opcode, bus.rt_rd, bus.rs, bus.signIn};
         end
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign count     = count_q;
   assign full      = full_w;
   assign done      = (state_q == DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_ins_encoder.sv
module tb_ins_encoder;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [AW:0]   count;
   logic          full, done, err;

   ins_encoder_if bus ();

   ins_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: program-load status in terms of the documented behaviour.
   bit   m_loading = 0;   // accepting words
   bit   m_done    = 0;
   bit   m_err     = 0;
   int   m_cnt     = 0;
   int   m_last_addr = 0;
   int   m_last_data = 0;
   bit   mon_en    = 0;

   // Expected writes visible in the current cycle: {addr, data}
   logic [11:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Write monitor: every expected write must appear exactly in its cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_write", 1, 0);
            end else begin
               logic [11:0] e;
               e = exp_q.pop_front();
               check("write_addr", int'(mem_addr), int'(e[11:8]));
               check("write_data", int'(mem_wdata), int'(e[7:0]));
            end
         end else begin
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               check("missing_write", 0, 1);
            end
            check("hold_addr", int'(mem_addr), m_last_addr);
            check("hold_data", int'(mem_wdata), m_last_data);
         end
      end
   end

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic step(input bit r, input bit s, input bit v,
                       input logic [7:0] w, input bit l);
      bit exp_ready, acc;
      rst          = r;
      start        = s;
      bus.in_valid = v;
      bus.opcode   = w[7:5];
      bus.rt_rd    = w[4];
      bus.rs       = w[3];
      bus.signIn   = w[2:0];
      bus.last     = l;
      @(negedge clk);
      exp_ready = m_loading && (m_cnt < DEPTH) && !s;
      check("in_ready", int'(bus.in_ready), int'(exp_ready));
      check("count", int'(count), m_cnt);
      check("full", int'(full), int'(m_cnt == DEPTH));
      check("done", int'(done), int'(m_done));
      check("err", int'(err), int'(m_err));
      acc = v && exp_ready && !r;
      @(posedge clk);
      #1;
      if (r) begin
         m_loading = 0; m_done = 0; m_err = 0; m_cnt = 0;
         m_last_addr = 0; m_last_data = 0;
      end else if (s) begin
         m_loading = 1; m_done = 0; m_err = 0; m_cnt = 0;
      end else begin
         if (acc) begin
            exp_q.push_back({4'(m_cnt), w});
            m_last_addr = m_cnt;
            m_last_data = int'(w);
            m_cnt++;
            if (l) begin
               m_loading = 0;
               m_done    = 1;
            end
         end else if (m_loading && m_cnt == DEPTH && v) begin
            m_err = 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0);
   endtask

   initial begin
      rst = 1; start = 0;
      bus.in_valid = 0; bus.opcode = 0; bus.rt_rd = 0;
      bus.rs = 0; bus.signIn = 0; bus.last = 0;
      @(posedge clk); #1;
      mon_en = 1;
      step(1, 0, 0, 8'h00, 0);
      check("reset_mem_we", int'(mem_we), 0);
      check("reset_addr", int'(mem_addr), 0);
      check("reset_wdata", int'(mem_wdata), 0);
      idle(2);

      // Single instruction: 101_1_0_011 = 0xB3
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 1, 8'hB3, 1);
      check("single_we", int'(mem_we), 1);
      check("single_data", int'(mem_wdata), 8'hB3);
      idle(2);

      // Burst of 4
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 1, 8'h11, 0);
      step(0, 0, 1, 8'h22, 0);
      step(0, 0, 1, 8'h33, 0);
      step(0, 0, 1, 8'h44, 1);
      idle(2);

      // Gaps
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 1, 8'h5A, 0);
      step(0, 0, 0, 8'hFF, 1);
      step(0, 0, 1, 8'hA5, 1);
      step(0, 0, 0, 8'h00, 0);
      idle(1);

      // Overflow: 16 without last, then one more offer
      step(0, 1, 0, 8'h00, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i * 7 + 1), 0);
      step(0, 0, 1, 8'hEE, 0);
      step(0, 0, 0, 8'h00, 0);
      check("overflow_err", int'(err), 1);
      step(0, 1, 0, 8'h00, 0);
      idle(1);

      // Exact fill with last on the 16th word
      step(0, 1, 0, 8'h00, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i * 13 + 2), i == DEPTH - 1);
      check("fill_addr", int'(mem_addr), DEPTH - 1);
      idle(2);

      // Reset on the 3rd handshake, then IDLE ignores in_valid
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 1, 8'h61, 0);
      step(0, 0, 1, 8'h62, 0);
      step(1, 0, 1, 8'h63, 0);
      check("rst_no_we", int'(mem_we), 0);
      step(0, 0, 1, 8'h64, 1);
      step(0, 0, 1, 8'h65, 0);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 1) == 1, 8'($urandom),
              $urandom_range(0, 29) == 0);
      end
      idle(2);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
